// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART receive path.
// The optional SPART_RX_PARITY_EN macro (see spart_rx_param) enables the PARITY state.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;
  localparam int SUB_W      = $clog2(OVERSAMPLE);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/spart_rx_fifo.sv
// Show-ahead receive FIFO: head is visible combinationally, pointers carry an extra wrap bit.
// A push while full is dropped unless a pop happens in the same cycle.
module spart_rx_fifo
  import spart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  // Head reads as zero while empty so the bus sees clean zeros after reset.
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spart_rx_param.sv
// SPART receive path: 16x oversampled serial receiver with majority voting and a receive FIFO.
// Define SPART_RX_PARITY_EN to add a parity bit per frame and a live parity_err flag.
module spart_rx_param
  import spart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic [DIV_W-1:0]     divisor,
  input  logic                 rd_en,
  input  logic                 clr_err,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = 1;
  localparam logic [SUB_W-1:0] SUB_ONE  = 1;
  localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(SAMPLE_MID);
  localparam logic [SUB_W-1:0] SUB_S6   = SUB_W'(SAMPLE_MID - 2);
  localparam logic [SUB_W-1:0] SUB_S7   = SUB_W'(SAMPLE_MID - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = 1;

  logic                 rxd_s1;
  logic                 rxd_s2;
  logic                 rxd_last;
  logic                 last_n;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     tick_cnt;
  logic                 tick;
  rx_state_t            state;
  rx_state_t            state_n;
  logic [SUB_W-1:0]     sub;
  logic [SUB_W-1:0]     sub_n;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_n;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_n;
  logic                 s6_q;
  logic                 s6_n;
  logic                 s7_q;
  logic                 s7_n;
  logic                 bit_val;
  logic                 push_q;
  logic                 push_n;
  logic                 ferr_set;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_drop;
`ifdef SPART_RX_PARITY_EN
  logic                 perr_set;
`else
  logic                 parity_unused;
  assign parity_unused = parity_odd;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
    end
  end

  // A new divisor is latched only at a wrap (or while halted), so a live change never truncates a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      div_q    <= '0;
    end else if (div_q == '0 || tick) begin
      tick_cnt <= '0;
      div_q    <= divisor;
    end else begin
      tick_cnt <= tick_cnt + DIV_ONE;
    end
  end

  assign tick    = (div_q != '0) && (tick_cnt == div_q - DIV_ONE);
  assign bit_val = maj3(s6_q, s7_q, rxd_s2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sub      <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      s6_q     <= 1'b1;
      s7_q     <= 1'b1;
      rxd_last <= 1'b1;
      push_q   <= 1'b0;
    end else begin
      state    <= state_n;
      sub      <= sub_n;
      bit_cnt  <= bit_n;
      shift_q  <= shift_n;
      s6_q     <= s6_n;
      s7_q     <= s7_n;
      rxd_last <= last_n;
      push_q   <= push_n;
    end
  end

  // Edge detection compares tick-rate samples, so a line held low after a break never re-arms.
  always_comb begin
    state_n  = state;
    sub_n    = sub;
    bit_n    = bit_cnt;
    shift_n  = shift_q;
    s6_n     = s6_q;
    s7_n     = s7_q;
    last_n   = rxd_last;
    push_n   = 1'b0;
    ferr_set = 1'b0;
`ifdef SPART_RX_PARITY_EN
    perr_set = 1'b0;
`endif
    if (tick) begin
      last_n = rxd_s2;
      sub_n  = sub + SUB_ONE;
      if (sub == SUB_S6) s6_n = rxd_s2;
      if (sub == SUB_S7) s7_n = rxd_s2;
      case (state)
        IDLE: begin
          sub_n = '0;
          bit_n = '0;
          if (rxd_last && !rxd_s2) state_n = START;
        end
        START: begin
          if (sub == SUB_MID && bit_val) state_n = IDLE;
          else if (sub == SUB_LAST)      state_n = DATA;
        end
        DATA: begin
          if (sub == SUB_MID) shift_n = {bit_val, shift_q[DATA_BITS-1:1]};
          if (sub == SUB_LAST) begin
            if (bit_cnt == BIT_LAST) begin
              bit_n = '0;
`ifdef SPART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              bit_n = bit_cnt + BIT_ONE;
            end
          end
        end
`ifdef SPART_RX_PARITY_EN
        PARITY: begin
          if (sub == SUB_MID && bit_val != ((^shift_q) ^ parity_odd)) perr_set = 1'b1;
          if (sub == SUB_LAST) state_n = STOP;
        end
`endif
        STOP: begin
          if (sub == SUB_MID) begin
            state_n = IDLE;
            if (bit_val) push_n   = 1'b1;
            else         ferr_set = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  spart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (shift_q),
    .pop       (rd_en),
    .head      (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .drop      (fifo_drop)
  );

  assign rda = !fifo_empty;

  // A new error event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set  | (frame_err & ~clr_err);
      overrun   <= fifo_drop | (overrun & ~clr_err);
    end
  end

`ifdef SPART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err <= 1'b0;
    else      parity_err <= perr_set | (parity_err & ~clr_err);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx_param.sv
// Self-checking bench for spart_rx_param: drives serial frames and compares against a queue-based model.
// Build with SPART_RX_PARITY_EN defined to also exercise the parity path.
module tb_spart_rx_param;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_W      = 16;
`ifdef SPART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int STOP_IDX = 1 + DATA_BITS + PAR_BITS;

  logic                 clk        = 1'b0;
  logic                 rst        = 1'b0;
  logic                 rxd        = 1'b1;
  logic [DIV_W-1:0]     divisor    = '0;
  logic                 rd_en      = 1'b0;
  logic                 clr_err    = 1'b0;
  logic                 parity_odd = 1'b0;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;

  int checks   = 0;
  int failures = 0;
  int div_now  = 163;

  logic [7:0] exp_q[$];
  logic       exp_ferr = 1'b0;
  logic       exp_ovr  = 1'b0;
  logic       exp_perr = 1'b0;

  always #1 clk = ~clk;

  spart_rx_param #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .divisor    (divisor),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rda        (rda),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic v, input int ticks);
    rxd = v;
    wait_clk(ticks * div_now);
  endtask

  // Reference: a good stop bit delivers the byte unless the FIFO already holds FIFO_DEPTH bytes.
  function automatic void model_frame(input logic [7:0] data, input logic stop_ok, input logic par_flip);
    if (PAR_BITS != 0 && par_flip) exp_perr = 1'b1;
    if (!stop_ok)                           exp_ferr = 1'b1;
    else if (exp_q.size() == FIFO_DEPTH)    exp_ovr  = 1'b1;
    else                                    exp_q.push_back(data);
  endfunction

  task automatic applyStimulus(input logic [7:0] data, input logic stop_val, input int glitch_bit,
                               input logic par_flip);
    hold(1'b0, 16);
    for (int i = 0; i < DATA_BITS; i++) begin
      if (i == glitch_bit) begin
        hold(data[i], 8);
        hold(!data[i], 1);
        hold(data[i], 7);
      end else begin
        hold(data[i], 16);
      end
    end
`ifdef SPART_RX_PARITY_EN
    hold((^data) ^ parity_odd ^ par_flip, 16);
`endif
    hold(stop_val, 16);
    model_frame(data, stop_val, par_flip);
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_rda"}, rda, exp_q.size() != 0);
    if (exp_q.size() != 0) checkOutput({tag, "_data"}, rx_data, exp_q[0]);
    checkOutput({tag, "_frame_err"}, frame_err, exp_ferr);
    checkOutput({tag, "_overrun"}, overrun, exp_ovr);
    checkOutput({tag, "_parity_err"}, parity_err, exp_perr);
  endtask

  task automatic popAndCheck(input string tag);
    checkAll(tag);
    rd_en = 1'b1;
    wait_clk(1);
    rd_en = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    wait_clk(1);
  endtask

  task automatic pulseClear();
    clr_err = 1'b1;
    wait_clk(1);
    clr_err = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    exp_perr = 1'b0;
  endtask

  initial begin : main
    int rise;
    int mid;
    logic [7:0] b;

    divisor = DIV_W'(div_now);
    wait_clk(4);
    checkOutput("reset_rda", rda, 0);
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_parity_err", parity_err, 0);
    rst = 1'b1;
    wait_clk(200);

    $display("[TB] single frame 0xA5 at divisor 163");
    rise = -1;
    mid  = (STOP_IDX * 16 + 8) * div_now;
    fork
      applyStimulus(8'hA5, 1'b1, -1, 1'b0);
      begin
        for (int c = 1; c <= (STOP_IDX + 2) * 16 * div_now && rise < 0; c++) begin
          @(negedge clk);
          if (rda) rise = c;
        end
      end
    join
    checkOutput("t1_rda_rise_window", (rise >= mid) && (rise <= mid + 2 * div_now + 8), 1);
    popAndCheck("t1");
    checkOutput("t1_rda_after_pop", rda, 0);

    div_now = $urandom_range(2, 4);
    divisor = DIV_W'(div_now);
    wait_clk(200);

    $display("[TB] back-to-back frames at divisor %0d", div_now);
    applyStimulus(8'hA5, 1'b1, -1, 1'b0);
    applyStimulus(8'hE7, 1'b1, -1, 1'b0);
    applyStimulus(8'h24, 1'b1, -1, 1'b0);
    hold(1'b1, 16);
    for (int i = 0; i < 3; i++) popAndCheck("t2");
    checkOutput("t2_rda_empty", rda, 0);

    $display("[TB] false start");
    hold(1'b0, 4);
    hold(1'b1, 24);
    checkOutput("t3_false_start_rda", rda, 0);
    checkOutput("t3_false_start_ferr", frame_err, 0);
    applyStimulus(8'h3C, 1'b1, -1, 1'b0);
    hold(1'b1, 16);
    popAndCheck("t3");

    $display("[TB] framing error and break");
    applyStimulus(8'h55, 1'b0, -1, 1'b0);
    hold(1'b0, 32);
    checkAll("t4_ferr");
    pulseClear();
    hold(1'b0, 16 * 12);
    checkAll("t4_break");
    hold(1'b1, 32);

    $display("[TB] divisor zero halts the receiver");
    divisor = '0;
    wait_clk(10);
    hold(1'b0, 16 * 5);
    hold(1'b1, 16 * 6);
    checkOutput("halt_rda", rda, 0);
    checkOutput("halt_frame_err", frame_err, 0);
    divisor = DIV_W'(div_now);
    wait_clk(20);

    $display("[TB] overrun and glitch rejection");
    for (int f = 0; f <= FIFO_DEPTH; f++) begin
      b = 8'($urandom);
      applyStimulus(b, 1'b1, (f == 2) ? int'($urandom_range(0, DATA_BITS - 1)) : -1, 1'b0);
      if ($urandom_range(0, 1) == 1) hold(1'b1, 3);
    end
    hold(1'b1, 16);
    checkAll("t5_full");
    for (int i = 0; i < FIFO_DEPTH; i++) popAndCheck("t5_pop");
    checkOutput("t5_rda_empty", rda, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'($urandom), 1'b1, -1, 1'b0);
    hold(1'b1, 8);
    hold(1'b0, 16 * 3);
    rst = 1'b0;
    rxd = 1'b1;
    wait_clk(3);
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    exp_perr = 1'b0;
    checkOutput("rst_mid_rda", rda, 0);
    checkOutput("rst_mid_rx_data", rx_data, 0);
    checkOutput("rst_mid_frame_err", frame_err, 0);
    checkOutput("rst_mid_overrun", overrun, 0);
    checkOutput("rst_mid_parity_err", parity_err, 0);
    rst = 1'b1;
    hold(1'b1, 32);
    b = 8'($urandom);
    applyStimulus(b, 1'b1, -1, 1'b0);
    hold(1'b1, 16);
    popAndCheck("rst_clean");

`ifdef SPART_RX_PARITY_EN
    $display("[TB] parity mismatch");
    parity_odd = 1'b0;
    applyStimulus(8'h07, 1'b1, -1, 1'b1);
    hold(1'b1, 16);
    popAndCheck("t6_parity_err");
    pulseClear();
    parity_odd = 1'b1;
    applyStimulus(8'($urandom), 1'b1, -1, 1'b0);
    hold(1'b1, 16);
    popAndCheck("t6_parity_ok");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
